// File: rtl/sprite_layer_mux.sv
// sprite_layer_mux: N_OBJ solid-rectangle overlay with fixed index priority and per-frame position latch.
// Define SPRITE_OVERLAP_EN to build the per-frame hero overlap accumulator behind hit_flags.
module sprite_layer_mux #(
    parameter int N_OBJ = 4,
    parameter int OBJ_W = 40,
    parameter int OBJ_H = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [10:0]          hcount_in,
    input  logic [10:0]          vcount_in,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 hblnk_in,
    input  logic                 vblnk_in,
    input  logic [11:0]          rgb_in,
    input  logic [12*N_OBJ-1:0]  x_pos,
    input  logic [12*N_OBJ-1:0]  y_pos,
    input  logic [12*N_OBJ-1:0]  color,
    input  logic [N_OBJ-1:0]     obj_en,
    output logic [10:0]          hcount_out,
    output logic [10:0]          vcount_out,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 hblnk_out,
    output logic                 vblnk_out,
    output logic [11:0]          rgb_out,
    output logic [N_OBJ-1:0]     hit_flags,
    output logic                 frame_tick
);
    localparam logic [12:0] W = 13'(OBJ_W);
    localparam logic [12:0] H = 13'(OBJ_H);

    logic                vblnk_d, latch, armed;
    logic [12*N_OBJ-1:0] xs, ys, cs;
    logic [N_OBJ-1:0]    en_s, hit, hit1;
    logic [11:0]         rgb1, pix;
    logic [10:0]         hc1, vc1;
    logic                hs1, vs1, hb1, vb1;

    assign latch = vblnk_in && !vblnk_d;

    // 13-bit sums so objects near the right/bottom edge never wrap to column/row 0
    always_comb begin
        hit = '0;
        for (int k = 0; k < N_OBJ; k++)
            hit[k] = en_s[k]
                && ({1'b0, xs[12*k +: 12]} <= {2'b0, hcount_in})
                && ({2'b0, hcount_in} < {1'b0, xs[12*k +: 12]} + W)
                && ({1'b0, ys[12*k +: 12]} <= {2'b0, vcount_in})
                && ({2'b0, vcount_in} < {1'b0, ys[12*k +: 12]} + H);
    end

    always_comb begin
        pix = rgb1;
        for (int k = N_OBJ - 1; k >= 0; k--)
            pix = hit1[k] ? color_at(k) : pix;
    end

    function automatic logic [11:0] color_at(input int k);
        return cs[12*k +: 12];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_d    <= 1'b0;
            armed      <= 1'b0;
            frame_tick <= 1'b0;
            xs         <= '0;
            ys         <= '0;
            cs         <= '0;
            en_s       <= '0;
            hit1       <= '0;
            rgb1       <= '0;
            hc1        <= '0;
            vc1        <= '0;
            hs1        <= 1'b0;
            vs1        <= 1'b0;
            hb1        <= 1'b0;
            vb1        <= 1'b0;
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            vblnk_d    <= vblnk_in;
            frame_tick <= latch;
            armed      <= armed || latch;
            if (latch) begin
                xs   <= x_pos;
                ys   <= y_pos;
                cs   <= color;
                en_s <= obj_en;
            end
            hit1       <= hit;
            rgb1       <= rgb_in;
            hc1        <= hcount_in;
            vc1        <= vcount_in;
            hs1        <= hsync_in;
            vs1        <= vsync_in;
            hb1        <= hblnk_in;
            vb1        <= vblnk_in;
            hcount_out <= hc1;
            vcount_out <= vc1;
            hsync_out  <= hs1;
            vsync_out  <= vs1;
            hblnk_out  <= hb1;
            vblnk_out  <= vb1;
            // until the first latch after reset the shadows are empty, so show blank colour
            rgb_out    <= (hb1 || vb1 || !armed) ? 12'h000 : pix;
        end
    end

`ifdef SPRITE_OVERLAP_EN
    logic [N_OBJ-1:0] acc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            hit_flags <= '0;
        end else if (latch) begin
            hit_flags <= acc;
            acc       <= '0;
        end else if (!hb1 && !vb1 && hit1[0]) begin
            acc <= acc | (hit1 & ~N_OBJ'(1));
        end
    end
`else
    assign hit_flags = '0;
`endif
endmodule

// File: tb/tb_sprite_layer_mux.sv
// tb_sprite_layer_mux: directed-vector bench for sprite_layer_mux with default parameters.
module tb_sprite_layer_mux;
    logic        clk = 1'b0, rst = 1'b1;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [47:0] x_pos = '0, y_pos = '0, color = '0;
    logic [3:0]  obj_en = '0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out, frame_tick;
    logic [11:0] rgb_out;
    logic [3:0]  hit_flags;
    int          errors = 0, checks = 0;

    sprite_layer_mux dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .x_pos(x_pos), .y_pos(y_pos), .color(color), .obj_en(obj_en),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .hit_flags(hit_flags), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_obj(input int k, input logic [11:0] x, input logic [11:0] y,
                           input logic [11:0] c, input logic en);
        x_pos[12*k +: 12] = x;
        y_pos[12*k +: 12] = y;
        color[12*k +: 12] = c;
        obj_en[k] = en;
    endtask

    task automatic pix(input string tag, input logic [10:0] h, input logic [10:0] v,
                       input logic hb, input logic [11:0] r, input logic [11:0] exp);
        hcount_in = h; vcount_in = v; hblnk_in = hb; hsync_in = hb; vblnk_in = 1'b0; rgb_in = r;
        repeat (2) @(posedge clk);
        #1 check(tag, rgb_out, exp);
    endtask

    task automatic vlatch(input logic [3:0] exp_hits);
        hblnk_in = 1'b1; vblnk_in = 1'b0;
        @(posedge clk); #1 vblnk_in = 1'b1; vsync_in = 1'b1;
        @(posedge clk); #1;
        check("tick_hi", frame_tick, 1);
        check("hit_flags", hit_flags, exp_hits);
        @(posedge clk); #1;
        check("tick_lo", frame_tick, 0);
        vblnk_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #22;
        check("rst_rgb", rgb_out, 0);
        check("rst_tick", frame_tick, 0);
        rst = 1'b0;
        pix("pre_latch", 10, 10, 0, 12'h123, 12'h000);

        set_obj(1, 100, 200, 12'h0f0, 1);
        vlatch(4'b0000);
        pix("o1_tl", 100, 200, 0, 12'h111, 12'h0f0);
        pix("o1_br", 139, 239, 0, 12'h111, 12'h0f0);
        pix("o1_right", 140, 200, 0, 12'h111, 12'h111);
        pix("o1_left", 99, 200, 0, 12'h111, 12'h111);
        pix("o1_below", 100, 240, 0, 12'h111, 12'h111);

        hcount_in = 100; vcount_in = 200; rgb_in = 12'h111;
        @(posedge clk); #1 hcount_in = 150;
        @(posedge clk); #1;
        check("lat_h", hcount_out, 100);
        check("lat_rgb", rgb_out, 12'h0f0);
        @(posedge clk); #1;
        check("lat_h2", hcount_out, 150);
        check("lat_rgb2", rgb_out, 12'h111);

        set_obj(1, 0, 0, 0, 0);
        set_obj(0, 300, 300, 12'hf00, 1);
        set_obj(2, 300, 300, 12'h00f, 1);
        vlatch(4'b0000);
        pix("prio", 310, 310, 0, 12'h111, 12'hf00);
        pix("prio_hblnk", 310, 310, 1, 12'h111, 12'h000);
        set_obj(0, 0, 0, 0, 0);
        vlatch(4'b0000);
        pix("o2_only", 310, 310, 0, 12'h111, 12'h00f);

        set_obj(2, 0, 0, 0, 0);
        set_obj(0, 100, 200, 12'hf00, 1);
        vlatch(4'b0000);
        pix("mid_old_a", 100, 220, 0, 12'h111, 12'hf00);
        x_pos[11:0] = 400;
        pix("mid_old_b", 100, 225, 0, 12'h111, 12'hf00);
        pix("mid_new_off", 400, 225, 0, 12'h111, 12'h111);
        vlatch(4'b0000);
        pix("next_new", 400, 225, 0, 12'h111, 12'hf00);
        pix("next_old_off", 100, 225, 0, 12'h111, 12'h111);

        set_obj(0, 4095, 0, 12'hf00, 1);
        vlatch(4'b0000);
        pix("nowrap_0", 0, 10, 0, 12'h111, 12'h111);
        pix("nowrap_38", 38, 10, 0, 12'h111, 12'h111);

        set_obj(0, 100, 100, 12'hf00, 1);
        set_obj(3, 130, 130, 12'h00f, 1);
        set_obj(1, 900, 700, 12'h0f0, 1);
        vlatch(4'b0000);
        pix("ov_pix", 135, 135, 0, 12'h111, 12'hf00);
`ifdef SPRITE_OVERLAP_EN
        vlatch(4'b1000);
`else
        vlatch(4'b0000);
`endif
        set_obj(3, 600, 600, 12'h00f, 1);
        pix("ov_pix2", 135, 135, 0, 12'h111, 12'hf00);
`ifdef SPRITE_OVERLAP_EN
        vlatch(4'b1000);
`else
        vlatch(4'b0000);
`endif
        pix("ov_pix3", 135, 135, 0, 12'h111, 12'hf00);
        vlatch(4'b0000);

        set_obj(0, 480, 100, 12'h0ff, 1);
        vlatch(4'b0000);
        pix("pre_rst", 500, 110, 0, 12'h111, 12'h0ff);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rgb", rgb_out, 0);
        check("mid_rst_h", hcount_out, 0);
        check("mid_rst_v", vcount_out, 0);
        check("mid_rst_flags", hit_flags, 0);
        @(negedge clk) rst = 1'b0;
        pix("post_rst_a", 500, 110, 0, 12'h111, 12'h000);
        pix("post_rst_b", 20, 20, 0, 12'h111, 12'h000);
        vlatch(4'b0000);
        pix("post_latch", 500, 110, 0, 12'h111, 12'h0ff);
        pix("post_latch_bg", 20, 20, 0, 12'h111, 12'h111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
